// File: rtl/multi_countdown_core.sv
// multi_countdown_core: N independent MM:SS BCD timer channels sharing one
// 1 s count-enable tick, driven by a single command port. Each channel counts
// down (cook timer) or up (stopwatch), latches its own alarm and emits a
// one-cycle done pulse on entry to ALARM. One channel is muxed out to the
// seven-segment display through a registered port.
module multi_countdown_core #(
    parameter int CHANNELS     = 4,
    parameter int CW           = 2,
    parameter int MAX_TENS_MIN = 9
) (
    input  logic                clk,
    input  logic                reset,          // asynchronous, active-low
    input  logic                count_enable,
    input  logic                cmd_valid,
    input  logic [CW-1:0]       cmd_chan,
    input  logic [2:0]          cmd_op,
    input  logic [15:0]         cmd_time,
    output logic                cmd_err,
    input  logic [CW-1:0]       disp_sel,
    output logic [15:0]         disp_time,
    output logic [CHANNELS-1:0] running,
    output logic [CHANNELS-1:0] alarm,
    output logic [CHANNELS-1:0] done_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_ALARM  = 2'd3
    } chan_state_t;

    localparam logic [2:0] OP_LOAD_DOWN = 3'd0;
    localparam logic [2:0] OP_LOAD_UP   = 3'd1;
    localparam logic [2:0] OP_START     = 3'd2;
    localparam logic [2:0] OP_PAUSE     = 3'd3;
    localparam logic [2:0] OP_CLEAR     = 3'd4;
    localparam logic [2:0] OP_ACK       = 3'd5;

    // Up-count ceiling {MAX_TENS_MIN,9}:59
    localparam logic [15:0] CEIL = {4'(MAX_TENS_MIN), 12'h959};

    chan_state_t          state_q [CHANNELS];
    chan_state_t          state_d [CHANNELS];
    logic [15:0]          time_q  [CHANNELS];
    logic [15:0]          time_d  [CHANNELS];
    logic [CHANNELS-1:0]  mode_up_q;
    logic [CHANNELS-1:0]  mode_up_d;
    logic [CHANNELS-1:0]  done_d;
    logic                 err_d;
    logic [15:0]          disp_d;
    logic                 chan_ok;
    logic                 load_ok;

    // BCD decrement with borrow through sec, tens_sec and min; caller
    // guarantees the time is non-zero.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // BCD increment with carry through sec, tens_sec and min; caller
    // guarantees the time is below the ceiling.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    r[11:8] = t[11:8] + 4'd1;
                end else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = t[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Command sanity: channel in range, and LOAD_DOWN time is legal BCD
    always_comb begin
        chan_ok = ({1'b0, cmd_chan} < (CW+1)'(CHANNELS));
        load_ok = (cmd_time[15:12] <= 4'(MAX_TENS_MIN)) &&
                  (cmd_time[11:8]  <= 4'd9) &&
                  (cmd_time[7:4]   <= 4'd5) &&
                  (cmd_time[3:0]   <= 4'd9);
    end

    // Per-channel next state: an addressed command wins over the tick,
    // otherwise a RUN channel counts on count_enable
    always_comb begin
        err_d = cmd_valid && !chan_ok;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            state_d[ch]   = state_q[ch];
            time_d[ch]    = time_q[ch];
            mode_up_d[ch] = mode_up_q[ch];
            if (cmd_valid && chan_ok && (cmd_chan == CW'(ch))) begin
                case (cmd_op)
                    OP_LOAD_DOWN: begin
                        if (state_q[ch] == ST_RUN || !load_ok) begin
                            err_d = 1'b1;
                        end else begin
                            time_d[ch]    = cmd_time;
                            mode_up_d[ch] = 1'b0;
                            state_d[ch]   = ST_IDLE;
                        end
                    end
                    OP_LOAD_UP: begin
                        if (state_q[ch] == ST_RUN) begin
                            err_d = 1'b1;
                        end else begin
                            time_d[ch]    = 16'h0000;
                            mode_up_d[ch] = 1'b1;
                            state_d[ch]   = ST_IDLE;
                        end
                    end
                    OP_START: begin
                        if (state_q[ch] == ST_ALARM) begin
                            err_d = 1'b1;
                        end else if (state_q[ch] != ST_RUN) begin
                            if (!mode_up_q[ch] && time_q[ch] == 16'h0000) begin
                                err_d = 1'b1;
                            end else begin
                                state_d[ch] = ST_RUN;
                            end
                        end
                    end
                    OP_PAUSE: begin
                        if (state_q[ch] == ST_RUN) begin
                            state_d[ch] = ST_PAUSED;
                        end
                    end
                    OP_CLEAR: begin
                        time_d[ch]  = 16'h0000;
                        state_d[ch] = ST_IDLE;
                    end
                    OP_ACK: begin
                        if (state_q[ch] == ST_ALARM) begin
                            state_d[ch] = ST_IDLE;
                        end
                    end
                    default: begin
                        err_d = 1'b1;
                    end
                endcase
            end else if (count_enable && state_q[ch] == ST_RUN) begin
                if (mode_up_q[ch]) begin
                    if (time_q[ch] == CEIL) begin
                        state_d[ch] = ST_ALARM;
                    end else begin
                        time_d[ch] = bcd_inc(time_q[ch]);
                        if (bcd_inc(time_q[ch]) == CEIL) begin
                            state_d[ch] = ST_ALARM;
                        end
                    end
                end else begin
                    time_d[ch] = bcd_dec(time_q[ch]);
                    if (time_q[ch] == 16'h0001) begin
                        state_d[ch] = ST_ALARM;
                    end
                end
            end
            done_d[ch] = (state_d[ch] == ST_ALARM) && (state_q[ch] != ST_ALARM);
        end
    end

    // Display mux; out-of-range selects read as zero
    always_comb begin
        disp_d = 16'h0000;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (disp_sel == CW'(ch)) begin
                disp_d = time_q[ch];
            end
        end
    end

    // State, time, mode and registered pulse/display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= ST_IDLE;
                time_q[ch]  <= 16'h0000;
            end
            mode_up_q  <= '0;
            done_pulse <= '0;
            cmd_err    <= 1'b0;
            disp_time  <= 16'h0000;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
                time_q[ch]  <= time_d[ch];
            end
            mode_up_q  <= mode_up_d;
            done_pulse <= done_d;
            cmd_err    <= err_d;
            disp_time  <= disp_d;
        end
    end

    // running/alarm decode straight from the state registers
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            running[ch] = (state_q[ch] == ST_RUN);
            alarm[ch]   = (state_q[ch] == ST_ALARM);
        end
    end

endmodule

// File: tb/tb_multi_countdown_core.sv
// Testbench for multi_countdown_core: two instances (MAX_TENS_MIN 9 and 0)
// share one stimulus stream; a seconds-based model predicts every output.
module tb_multi_countdown_core;

   localparam int NCH = 4;
   localparam int CWB = 3;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_ALARM = 3;

   logic        clk;
   logic        rst_n;
   logic        count_enable;
   logic        cmd_valid;
   logic [2:0]  cmd_chan;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_time;
   logic [2:0]  disp_sel;

   logic        a_err, b_err;
   logic [15:0] a_disp, b_disp;
   logic [3:0]  a_run, a_alarm, a_done;
   logic [3:0]  b_run, b_alarm, b_done;

   int n_checks = 0;
   int n_pass   = 0;
   bit checking = 0;

   int          m_state [2][NCH];
   int          m_secs  [2][NCH];
   bit          m_up    [2][NCH];
   bit          m_done  [2][NCH];
   bit          m_err   [2];
   logic [15:0] m_disp  [2];
   int          max_tm  [2] = '{9, 0};

   multi_countdown_core #(.CHANNELS(NCH), .CW(CWB), .MAX_TENS_MIN(9)) dut_a (
      .clk(clk), .reset(rst_n), .count_enable(count_enable),
      .cmd_valid(cmd_valid), .cmd_chan(cmd_chan), .cmd_op(cmd_op),
      .cmd_time(cmd_time), .cmd_err(a_err), .disp_sel(disp_sel),
      .disp_time(a_disp), .running(a_run), .alarm(a_alarm),
      .done_pulse(a_done)
   );

   multi_countdown_core #(.CHANNELS(NCH), .CW(CWB), .MAX_TENS_MIN(0)) dut_b (
      .clk(clk), .reset(rst_n), .count_enable(count_enable),
      .cmd_valid(cmd_valid), .cmd_chan(cmd_chan), .cmd_op(cmd_op),
      .cmd_time(cmd_time), .cmd_err(b_err), .disp_sel(disp_sel),
      .disp_time(b_disp), .running(b_run), .alarm(b_alarm),
      .done_pulse(b_done)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not reach the end of the stimulus");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [15:0] to_bcd(input int s);
      return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
   endfunction

   function automatic int from_bcd(input logic [15:0] t);
      return int'(t[15:12]) * 600 + int'(t[11:8]) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
   endfunction

   function automatic logic [15:0] vec_of(input int i, input int which);
      logic [15:0] v;
      v = 16'h0;
      for (int ch = 0; ch < NCH; ch++) begin
         case (which)
            0:       v[ch] = (m_state[i][ch] == M_RUN);
            1:       v[ch] = (m_state[i][ch] == M_ALARM);
            default: v[ch] = m_done[i][ch];
         endcase
      end
      return v;
   endfunction

   // One clock of the model for instance i, working in plain seconds
   task automatic model_step(input int i);
      int ceil_s, prev, ds;
      bit ok;
      ceil_s = max_tm[i] * 600 + 599;
      ds = int'(disp_sel);
      if (ds < NCH) m_disp[i] = to_bcd(m_secs[i][ds]);
      else m_disp[i] = 16'h0;
      ok = (int'(cmd_time[15:12]) <= max_tm[i]) && (cmd_time[11:8] <= 4'd9) &&
           (cmd_time[7:4] <= 4'd5) && (cmd_time[3:0] <= 4'd9);
      m_err[i] = cmd_valid && (int'(cmd_chan) >= NCH);
      for (int ch = 0; ch < NCH; ch++) begin
         prev = m_state[i][ch];
         if (cmd_valid && int'(cmd_chan) == ch) begin
            case (cmd_op)
               3'd0: if (prev == M_RUN || !ok) m_err[i] = 1;
                     else begin m_secs[i][ch] = from_bcd(cmd_time); m_up[i][ch] = 0; m_state[i][ch] = M_IDLE; end
               3'd1: if (prev == M_RUN) m_err[i] = 1;
                     else begin m_secs[i][ch] = 0; m_up[i][ch] = 1; m_state[i][ch] = M_IDLE; end
               3'd2: if (prev == M_ALARM) m_err[i] = 1;
                     else if (prev != M_RUN) begin
                        if (!m_up[i][ch] && m_secs[i][ch] == 0) m_err[i] = 1;
                        else m_state[i][ch] = M_RUN;
                     end
               3'd3: if (prev == M_RUN) m_state[i][ch] = M_PAUSED;
               3'd4: begin m_secs[i][ch] = 0; m_state[i][ch] = M_IDLE; end
               3'd5: if (prev == M_ALARM) m_state[i][ch] = M_IDLE;
               default: m_err[i] = 1;
            endcase
         end else if (count_enable && prev == M_RUN) begin
            if (m_up[i][ch]) begin
               if (m_secs[i][ch] < ceil_s) m_secs[i][ch]++;
               if (m_secs[i][ch] == ceil_s) m_state[i][ch] = M_ALARM;
            end else begin
               m_secs[i][ch]--;
               if (m_secs[i][ch] == 0) m_state[i][ch] = M_ALARM;
            end
         end
         m_done[i][ch] = (m_state[i][ch] == M_ALARM) && (prev != M_ALARM);
      end
   endtask

   // Model update on each clock edge, with asynchronous reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
               m_state[i][ch] = M_IDLE;
               m_secs[i][ch]  = 0;
               m_up[i][ch]    = 0;
               m_done[i][ch]  = 0;
            end
            m_err[i]  = 0;
            m_disp[i] = 16'h0;
         end
      end else begin
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
   endtask

   // Compare every output of both instances against the model mid-cycle
   always @(negedge clk) begin
      if (checking) begin
         checkOutput("a_cmd_err",    16'(a_err),   16'(m_err[0]));
         checkOutput("a_disp_time",  a_disp,       m_disp[0]);
         checkOutput("a_running",    16'(a_run),   vec_of(0, 0));
         checkOutput("a_alarm",      16'(a_alarm), vec_of(0, 1));
         checkOutput("a_done_pulse", 16'(a_done),  vec_of(0, 2));
         checkOutput("b_cmd_err",    16'(b_err),   16'(m_err[1]));
         checkOutput("b_disp_time",  b_disp,       m_disp[1]);
         checkOutput("b_running",    16'(b_run),   vec_of(1, 0));
         checkOutput("b_alarm",      16'(b_alarm), vec_of(1, 1));
         checkOutput("b_done_pulse", 16'(b_done),  vec_of(1, 2));
      end
   end

   // Drive one cycle of inputs, 2 ns after the rising edge
   task automatic applyStimulus(input logic v, input logic [2:0] ch, input logic [2:0] op,
                                input logic [15:0] t, input logic ce);
      @(posedge clk);
      #2;
      cmd_valid    = v;
      cmd_chan     = ch;
      cmd_op       = op;
      cmd_time     = t;
      count_enable = ce;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) applyStimulus(1'b0, 3'd0, 3'd0, 16'h0, 1'b0);
   endtask

   logic [2:0]  err_ch [5] = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd0};
   logic [2:0]  err_op [5] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd7};
   logic [15:0] err_t  [5] = '{16'h0A00, 16'h0060, 16'h0000, 16'h0005, 16'h0000};

   initial begin
      cmd_valid = 0; cmd_chan = 0; cmd_op = 0; cmd_time = 0;
      count_enable = 0; disp_sel = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      checking = 1;
      idle_cycles(2);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("lit_reset_disp", a_disp, 16'h0000);
      checkOutput("lit_reset_alarm", 16'(a_alarm), 16'h0000);

      // Reset while ch2 runs at 03:17
      disp_sel = 3'd2;
      applyStimulus(1, 3'd2, 3'd0, 16'h0317, 0);
      applyStimulus(1, 3'd2, 3'd2, 16'h0, 0);
      idle_cycles(2);
      @(negedge clk);
      checkOutput("lit_ch2_running", 16'(a_run), 16'h0004);
      checkOutput("lit_ch2_disp", a_disp, 16'h0317);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("lit_midrun_reset_disp", a_disp, 16'h0000);
      checkOutput("lit_midrun_reset_running", 16'(a_run), 16'h0000);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // ch0 counts down 00:02 to alarm, then ACK
      disp_sel = 3'd0;
      applyStimulus(1, 3'd0, 3'd0, 16'h0002, 0);
      applyStimulus(1, 3'd0, 3'd2, 16'h0, 0);
      applyStimulus(0, 3'd0, 3'd0, 16'h0, 1);
      idle_cycles(2);
      @(negedge clk);
      checkOutput("lit_ch0_0001", a_disp, 16'h0001);
      applyStimulus(0, 3'd0, 3'd0, 16'h0, 1);
      idle_cycles(1);
      @(negedge clk);
      checkOutput("lit_ch0_alarm", 16'(a_alarm), 16'h0001);
      checkOutput("lit_ch0_done", 16'(a_done), 16'h0001);
      checkOutput("lit_ch0_stopped", 16'(a_run), 16'h0000);
      idle_cycles(1);
      @(negedge clk);
      checkOutput("lit_ch0_done_gone", 16'(a_done), 16'h0000);
      checkOutput("lit_ch0_disp_0000", a_disp, 16'h0000);
      applyStimulus(1, 3'd0, 3'd5, 16'h0, 0);
      idle_cycles(1);
      @(negedge clk);
      checkOutput("lit_ch0_ack", 16'(a_alarm), 16'h0000);

      // ch1 10:00 borrow chain, pause and resume
      disp_sel = 3'd1;
      applyStimulus(1, 3'd1, 3'd0, 16'h1000, 0);
      applyStimulus(1, 3'd1, 3'd2, 16'h0, 0);
      applyStimulus(0, 3'd0, 3'd0, 16'h0, 1);
      idle_cycles(2);
      @(negedge clk);
      checkOutput("lit_ch1_0959", a_disp, 16'h0959);
      applyStimulus(1, 3'd1, 3'd3, 16'h0, 0);
      repeat (3) applyStimulus(0, 3'd0, 3'd0, 16'h0, 1);
      idle_cycles(2);
      @(negedge clk);
      checkOutput("lit_ch1_paused", a_disp, 16'h0959);
      applyStimulus(1, 3'd1, 3'd2, 16'h0, 0);
      applyStimulus(0, 3'd0, 3'd0, 16'h0, 1);
      idle_cycles(2);
      @(negedge clk);
      checkOutput("lit_ch1_0958", a_disp, 16'h0958);

      // Rejected commands
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, err_ch[k], err_op[k], err_t[k], 0);
         idle_cycles(1);
         @(negedge clk);
         checkOutput($sformatf("lit_err_case%0d", k), 16'(a_err), 16'h0001);
      end

      // Up-count to the 09:59 ceiling on the MAX_TENS_MIN=0 instance
      disp_sel = 3'd3;
      applyStimulus(1, 3'd3, 3'd1, 16'h1234, 0);
      applyStimulus(1, 3'd3, 3'd2, 16'h0, 0);
      repeat (599) applyStimulus(0, 3'd0, 3'd0, 16'h0, 1);
      idle_cycles(2);
      @(negedge clk);
      checkOutput("lit_b_ceiling", b_disp, 16'h0959);
      checkOutput("lit_b_ceiling_alarm", 16'(b_alarm), 16'h0008);
      repeat (5) applyStimulus(0, 3'd0, 3'd0, 16'h0, 1);
      idle_cycles(2);
      @(negedge clk);
      checkOutput("lit_b_saturated", b_disp, 16'h0959);
      checkOutput("lit_a_past_ceiling", a_disp, 16'h1004);

      // Tick coincident with PAUSE on ch0 while ch1 keeps counting
      applyStimulus(1, 3'd0, 3'd4, 16'h0, 0);
      applyStimulus(1, 3'd1, 3'd4, 16'h0, 0);
      applyStimulus(1, 3'd0, 3'd0, 16'h0005, 0);
      applyStimulus(1, 3'd1, 3'd0, 16'h0005, 0);
      applyStimulus(1, 3'd0, 3'd2, 16'h0, 0);
      applyStimulus(1, 3'd1, 3'd2, 16'h0, 0);
      applyStimulus(1, 3'd0, 3'd3, 16'h0, 1);
      disp_sel = 3'd0;
      idle_cycles(2);
      @(negedge clk);
      checkOutput("lit_ch0_held", a_disp, 16'h0005);
      checkOutput("lit_ch0_paused_run", 16'(a_run[1:0]), 16'h0002);
      disp_sel = 3'd1;
      idle_cycles(2);
      @(negedge clk);
      checkOutput("lit_ch1_counted", a_disp, 16'h0004);

      // Out-of-range display select
      disp_sel = 3'd5;
      idle_cycles(2);
      @(negedge clk);
      checkOutput("lit_disp_oor", a_disp, 16'h0000);

      checking = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multi_countdown_core.md
Name: multi_countdown_core

Overview:
- Parametrised successor to the single kitchen-timer datapath: N independent MM:SS BCD timer channels share one 1 s count-enable tick.
- Each channel counts down (cook timer) or up (stopwatch) under a single command port. Each channel has its own alarm latch and done pulse.
- A channel-select mux feeds one channel's time to the existing quad seven-segment display.
- Sits between the button/debounce/control logic and the display mux in the top-level timer.

Parameters:
- CHANNELS, 4, number of independent timer channels (1..16).
- CW, 2, width of channel index fields; must satisfy 2^CW >= CHANNELS.
- MAX_TENS_MIN, 9, largest legal tens-of-minutes digit. Also sets the up-count ceiling at {MAX_TENS_MIN,9}:59.

Ports:
- clk  in  1  system clock (5 MHz domain).
- reset  in  1  asynchronous, active-low reset.
- count_enable  in  1  one-cycle tick, nominally every 1 s.
- cmd_valid  in  1  command strobe, one cycle.
- cmd_chan  in  CW  target channel.
- cmd_op  in  3  0=LOAD_DOWN, 1=LOAD_UP, 2=START, 3=PAUSE, 4=CLEAR, 5=ACK; 6/7 reserved.
- cmd_time  in  16  BCD {tens_min, min, tens_sec, sec}, used only by LOAD_DOWN.
- cmd_err  out  1  one-cycle pulse on a rejected command.
- disp_sel  in  CW  channel routed to disp_time.
- disp_time  out  16  BCD time of the selected channel, registered.
- running  out  CHANNELS  channel is in RUN.
- alarm  out  CHANNELS  latched alarm (ALARM state).
- done_pulse  out  CHANNELS  one-cycle pulse on entry to ALARM.

Behaviour:
- reset low, asynchronous: all channels go to IDLE, time 00:00, mode DOWN. running, alarm, done_pulse, cmd_err and disp_time all read 0.
- Per-channel FSM states are IDLE, RUN, PAUSED, ALARM.
- LOAD_DOWN (from IDLE, PAUSED or ALARM): time <= cmd_time, mode <= DOWN, state <= IDLE, alarm cleared.
  - Rejected with cmd_err if any digit > 9, tens_sec > 5, or tens_min > MAX_TENS_MIN.
- LOAD_UP: time <= 00:00, mode <= UP, state <= IDLE. cmd_time is ignored.
- START:
  - From IDLE or PAUSED goes to RUN.
  - In DOWN mode with time 00:00, START is rejected (cmd_err) and the state is unchanged.
  - START while in RUN is a no-op with no error.
  - START while in ALARM is rejected.
- PAUSE: RUN goes to PAUSED. Issued in any other state it is a no-op.
- CLEAR: any state goes to IDLE with time 00:00; mode is retained and alarm is cleared.
- ACK: ALARM goes to IDLE with time retained. In other states it is a no-op.
- Any LOAD_*/START/PAUSE/CLEAR issued while in RUN or ALARM, other than the cases listed above, is rejected with cmd_err.
  - LOAD while in RUN: rejected (cmd_err). The channel must be paused first.
- Other rejections, each with cmd_err and no state change:
  - cmd_chan >= CHANNELS.
  - Reserved op.
- Counting happens only in RUN and only on cycles where count_enable=1.
- DOWN mode decrements with a BCD borrow chain:
  - sec 0 -> 9 with borrow.
  - tens_sec 0 -> 5 with borrow.
  - min 0 -> 9 with borrow.
  - Example: 10:00 -> 09:59.
  - The tick that makes the time 00:00 moves the channel to ALARM on the same edge. done_pulse is high for the following cycle.
- UP mode increments:
  - sec 9 -> 0 with carry.
  - tens_sec 5 -> 0 with carry.
  - min 9 -> 0 with carry into tens_min.
  - On reaching {MAX_TENS_MIN,9}:59 the channel saturates there and enters ALARM.
- In ALARM the time is frozen and the alarm output stays high until ACK, CLEAR or LOAD.
- Simultaneous command and count_enable on the same channel: the command wins and no count occurs that cycle. All other channels still count.
- Latencies:
  - All state and time updates are visible one cycle after the command or tick edge.
  - cmd_err is asserted in the cycle after a rejected cmd_valid.
  - disp_time is one cycle behind disp_sel or the channel time.
  - running and alarm are decoded directly from the state registers, with no extra delay.
- disp_sel >= CHANNELS: disp_time reads 0.

Test Plan:
- Reset mid-RUN (ch2 at 03:17) -> the next cycle shows all outputs 0 and every channel IDLE at 00:00.
- LOAD_DOWN ch0 00:02, START, then 2 ticks -> 00:01, then 00:00. alarm[0]=1, done_pulse[0] high for 1 cycle, running[0]=0. ACK -> alarm[0]=0.
- LOAD_DOWN ch1 10:00, START, 1 tick -> disp_time (disp_sel=1) = 16'h0959. PAUSE then 3 ticks -> still 09:59. START then 1 tick -> 09:58.
- LOAD_UP ch3 with MAX_TENS_MIN=0, preload by running 599 ticks -> 09:59 and ALARM asserted. Further ticks -> the time stays at 09:59.
- Error cases, each rejected with cmd_err pulse and no state change:
  - LOAD_DOWN 16'h0A00.
  - LOAD_DOWN 16'h0060.
  - START on ch0 in DOWN at 00:00.
  - cmd_chan=CHANNELS.
  - Op 7.
- START ch0 and ch1 running at 00:05; tick coincident with PAUSE on ch0 -> ch0 stays 00:05 (PAUSED) while ch1 -> 00:04.
